// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: the memory map, the MMIO
// register offsets and the STATUS bit layout. Test programs and the core
// testbench use the same constants.
package data_memory_responder_pkg;

  // Memory map
  localparam logic [31:0] RAM_BASE     = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE    = 32'h1001_0400;
  localparam int          MEMORY_DEPTH = 64;
  localparam int          FIFO_DEPTH   = 4;

  // MMIO register byte offsets from MMIO_BASE
  localparam logic [31:0] TXDATA_OFFSET = 32'h0;
  localparam logic [31:0] STATUS_OFFSET = 32'h4;
  localparam logic [31:0] CYCLE_OFFSET  = 32'h8;

  // STATUS register bit positions
  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 4;

  // Which MMIO register an address selects
  typedef enum logic [1:0] {
    MMIO_NONE,
    MMIO_TXDATA,
    MMIO_STATUS,
    MMIO_CYCLE
  } mmio_reg_e;

  // Assemble the STATUS read value from the FIFO flags and the overflow flag
  function automatic logic [31:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic       overflow,
                                              input logic [3:0] count);
    logic [31:0] word;
    word = '0;
    word[STATUS_FULL_BIT]                          = full;
    word[STATUS_EMPTY_BIT]                         = empty;
    word[STATUS_OVERFLOW_BIT]                      = overflow;
    word[STATUS_COUNT_LSB+3:STATUS_COUNT_LSB]      = count;
    return word;
  endfunction

endpackage

// File: rtl/data_memory_responder_tx_fifo.sv
// Transmit FIFO for the data-memory responder.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   push, push_data write one entry (caller only pushes when not full, or
//                   when a pop happens in the same cycle)
//   pop             remove the head entry (caller only pops when not empty)
//   full, empty     occupancy flags
//   count           number of stored entries
//   head            registered head entry
module data_memory_responder_tx_fifo #(
  parameter int depth = 4,
  parameter int width = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [width-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth):0]       count,
  output logic [width-1:0]             head
);

  localparam int                PTR_W      = $clog2(depth);
  localparam logic [PTR_W-1:0]  PTR_ONE    = 1;
  localparam logic [PTR_W:0]    CNT_ONE    = 1;
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(depth);

  logic [width-1:0] storage [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage, pointers and occupancy. Depth is a power of two so the pointers
  // wrap naturally. A simultaneous push and pop leaves the count unchanged.
  // Storage is cleared on reset so the head reads 0 straight after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = storage[rd_ptr];

endmodule

// File: rtl/data_memory_responder.sv
// Responder side of the processor data-memory interface. Serves the MEM
// stage with a word-addressed data RAM, an MMIO block (TXDATA, STATUS,
// CYCLE), a TX FIFO drained over an out_valid/out_ready stream and a
// free-running cycle counter. Read data is combinational.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   memread, memwrite     access requests from the core
//   data_address          byte address, bits [1:0] ignored
//   writedata             store data
//   received_data         read data, 0 unless a mapped read is in progress
//   out_data, out_valid   TX FIFO head byte and non-empty flag
//   out_ready             consumer takes the head when valid and ready
//   bus_error             sticky flag, set by any access to an unmapped address
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          memory_depth = MEMORY_DEPTH,
  parameter logic [31:0] ram_base     = RAM_BASE,
  parameter logic [31:0] mmio_base    = MMIO_BASE,
  parameter int          fifo_depth   = FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] received_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        bus_error
);

  localparam int          IDX_W     = $clog2(memory_depth);
  localparam int          CNT_W     = $clog2(fifo_depth) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(memory_depth * 4);

  logic [31:0]      word_addr;
  logic [31:0]      ram_offset;
  logic             ram_hit;
  logic [IDX_W-1:0] ram_index;
  mmio_reg_e        mmio_reg;
  logic             unmapped;

  logic [31:0]      ram [memory_depth];
  logic [31:0]      cycle;
  logic             overflow;

  logic             push_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow_set;
  logic             overflow_clear;

  // Address decode. The offset subtraction wraps to a huge value for
  // addresses below ram_base, so one unsigned compare covers both bounds.
  assign word_addr  = {data_address[31:2], 2'b00};
  assign ram_offset = word_addr - ram_base;
  assign ram_hit    = (ram_offset < RAM_BYTES);
  assign ram_index  = ram_offset[IDX_W+1:2];

  // Pick out the addressed MMIO register, if any
  always_comb begin
    mmio_reg = MMIO_NONE;
    if (word_addr == mmio_base + TXDATA_OFFSET) begin
      mmio_reg = MMIO_TXDATA;
    end else if (word_addr == mmio_base + STATUS_OFFSET) begin
      mmio_reg = MMIO_STATUS;
    end else if (word_addr == mmio_base + CYCLE_OFFSET) begin
      mmio_reg = MMIO_CYCLE;
    end
  end

  assign unmapped = !ram_hit && (mmio_reg == MMIO_NONE);

  // FIFO control. A push into a full FIFO still succeeds if the consumer
  // pops in the same cycle; only a push with no room at all is an overflow.
  assign fifo_pop       = out_valid && out_ready;
  assign push_req       = memwrite && (mmio_reg == MMIO_TXDATA);
  assign fifo_push      = push_req && (!fifo_full || fifo_pop);
  assign overflow_set   = push_req && fifo_full && !fifo_pop;
  assign overflow_clear = memwrite && (mmio_reg == MMIO_STATUS)
                          && writedata[STATUS_OVERFLOW_BIT];

  data_memory_responder_tx_fifo #(
    .depth (fifo_depth),
    .width (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (writedata[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (out_data)
  );

  assign out_valid = !fifo_empty;

  // Data RAM: synchronous write, no reset so contents survive a reset
  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) begin
      ram[ram_index] <= writedata;
    end
  end

  // Cycle counter and the two sticky flags. An overflow event in the same
  // cycle as a W1C clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle     <= '0;
      overflow  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
      if ((memread || memwrite) && unmapped) begin
        bus_error <= 1'b1;
      end
    end
  end

  // Read mux. A same-cycle write has not committed yet, so RAM reads return
  // the old word.
  always_comb begin
    received_data = '0;
    if (memread) begin
      if (ram_hit) begin
        received_data = ram[ram_index];
      end else begin
        case (mmio_reg)
          MMIO_STATUS: received_data = status_word(fifo_full, fifo_empty,
                                                   overflow, 4'(fifo_count));
          MMIO_CYCLE:  received_data = cycle;
          default:     received_data = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios followed
// by randomized traffic, all checked against a behavioural model that keeps
// the RAM as an array, the TX FIFO as a queue and the flags as plain bits.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] data_address;
  logic [31:0] writedata;
  logic [31:0] received_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bus_error;

  // Reference model state
  logic [31:0] ram_model [MEMORY_DEPTH];
  bit          ram_known [MEMORY_DEPTH];
  logic [7:0]  fifo_q [$];
  logic [31:0] cycle_model;
  bit          ovf_model;
  bit          bus_model;

  // Observed values from the most recent cycle
  logic [31:0] last_rd;
  logic [7:0]  last_out;
  logic        last_valid;
  logic        last_bus;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  data_memory_responder dut (
    .clk           (clk),
    .reset         (reset),
    .memread       (memread),
    .memwrite      (memwrite),
    .data_address  (data_address),
    .writedata     (writedata),
    .received_data (received_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .bus_error     (bus_error)
  );

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // 0 unmapped, 1 RAM, 2 TXDATA, 3 STATUS, 4 CYCLE
  function automatic int classify(input logic [31:0] addr);
    longint a;
    a = longint'(addr) & ~longint'(3);
    if (a >= longint'(RAM_BASE) && a < longint'(RAM_BASE) + 4 * MEMORY_DEPTH) return 1;
    if (a == longint'(MMIO_BASE)) return 2;
    if (a == longint'(MMIO_BASE) + 4) return 3;
    if (a == longint'(MMIO_BASE) + 8) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = fifo_q.size();
    return 32'(n * 16 + (ovf_model ? 4 : 0) + (n == 0 ? 2 : 0) + (n == FIFO_DEPTH ? 1 : 0));
  endfunction

  // One bus cycle: drive at the falling edge, check outputs shortly after,
  // then advance the model for the coming rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ready);
    int          kind;
    int          idx;
    bit          known;
    bit          do_pop;
    bit          was_full;
    bit          ovf_set;
    bit          ovf_clr;
    logic [31:0] expected;
    @(negedge clk);
    memread      = rd;
    memwrite     = wr;
    data_address = addr;
    writedata    = wdata;
    out_ready    = ready;
    #2;
    last_rd    = received_data;
    last_out   = out_data;
    last_valid = out_valid;
    last_bus   = bus_error;

    checkOutput("out_valid", 32'(out_valid), 32'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) checkOutput("out_data", 32'(out_data), 32'(fifo_q[0]));
    checkOutput("bus_error", 32'(bus_error), 32'(bus_model));

    kind     = classify(addr);
    idx      = int'((addr - RAM_BASE) >> 2);
    known    = 1'b1;
    expected = 32'h0;
    if (rd) begin
      case (kind)
        1: if (ram_known[idx]) expected = ram_model[idx]; else known = 1'b0;
        3: expected = model_status();
        4: expected = cycle_model;
        default: expected = 32'h0;
      endcase
    end
    if (known) checkOutput("received_data", received_data, expected);

    do_pop   = (fifo_q.size() != 0) && ready;
    was_full = (fifo_q.size() == FIFO_DEPTH);
    ovf_set  = 1'b0;
    ovf_clr  = 1'b0;
    if (do_pop) void'(fifo_q.pop_front());
    if (wr) begin
      case (kind)
        1: begin ram_model[idx] = wdata; ram_known[idx] = 1'b1; end
        2: if (!was_full || do_pop) fifo_q.push_back(wdata[7:0]); else ovf_set = 1'b1;
        3: ovf_clr = wdata[2];
        default: ;
      endcase
    end
    if (ovf_set) ovf_model = 1'b1;
    else if (ovf_clr) ovf_model = 1'b0;
    if ((rd || wr) && kind == 0) bus_model = 1'b1;
    cycle_model = cycle_model + 32'd1;
    @(posedge clk);
  endtask

  // Pulse reset in the low clock phase and check the reset state directly
  task automatic doReset();
    @(negedge clk);
    reset        = 1'b0;
    memread      = 1'b1;
    memwrite     = 1'b0;
    writedata    = 32'h0;
    out_ready    = 1'b0;
    data_address = MMIO_BASE + STATUS_OFFSET;
    fifo_q.delete();
    cycle_model = 32'h0;
    ovf_model   = 1'b0;
    bus_model   = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_out_data", 32'(out_data), 32'h0);
    checkOutput("reset_bus_error", 32'(bus_error), 32'h0);
    checkOutput("reset_status", received_data, 32'h0000_0002);
    data_address = MMIO_BASE + CYCLE_OFFSET;
    #1;
    checkOutput("reset_cycle", received_data, 32'h0);
    #1;
    reset   = 1'b1;
    memread = 1'b0;
    @(posedge clk);
    cycle_model = 32'h1;
  endtask

  initial begin
    logic [31:0] c0;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          pick;

    reset        = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    data_address = 32'h0;
    writedata    = 32'h0;
    out_ready    = 1'b0;
    cycle_model  = 32'h0;
    ovf_model    = 1'b0;
    bus_model    = 1'b0;
    for (int i = 0; i < MEMORY_DEPTH; i++) ram_known[i] = 1'b0;
    doReset();

    // RAM write/read, then same-cycle read+write returns the old word
    applyStimulus(1'b0, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h1001_0010, 32'h0, 1'b0);
    checkOutput("ram_readback", last_rd, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 32'h1001_0010, 32'h0000_1234, 1'b0);
    checkOutput("ram_rw_old", last_rd, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h1001_0013, 32'h0, 1'b0);
    checkOutput("ram_rw_new", last_rd, 32'h0000_1234);

    // Reset with three bytes queued; RAM contents survive
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, MMIO_BASE, 32'h60 + 32'(i), 1'b0);
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h1001_0010, 32'h0, 1'b0);
    checkOutput("ram_after_reset", last_rd, 32'h0000_1234);

    // Overfill with the consumer stalled, then drain in order
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, MMIO_BASE, 32'h41 + 32'(i), 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO_BASE + STATUS_OFFSET, 32'h0, 1'b0);
    checkOutput("status_overflow", last_rd, 32'h0000_0045);
    applyStimulus(1'b1, 1'b0, MMIO_BASE, 32'h0, 1'b0);
    checkOutput("txdata_read", last_rd, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("drain_order", 32'(last_out), 32'h41 + 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("drained_valid", 32'(last_valid), 32'h0);

    // W1C clear of overflow; bits other than bit 2 do nothing
    applyStimulus(1'b0, 1'b1, MMIO_BASE + STATUS_OFFSET, 32'hFFFF_FFFB, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO_BASE + STATUS_OFFSET, 32'h0, 1'b0);
    checkOutput("w1c_other_bits", last_rd, 32'h0000_0006);
    applyStimulus(1'b0, 1'b1, MMIO_BASE + STATUS_OFFSET, 32'h4, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO_BASE + STATUS_OFFSET, 32'h0, 1'b0);
    checkOutput("w1c_clear", last_rd, 32'h0000_0002);

    // Full FIFO, push while the consumer pops: no overflow
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, MMIO_BASE, 32'h50 + 32'(i), 1'b0);
    applyStimulus(1'b0, 1'b1, MMIO_BASE, 32'h55, 1'b1);
    applyStimulus(1'b1, 1'b0, MMIO_BASE + STATUS_OFFSET, 32'h0, 1'b0);
    checkOutput("full_push_pop", last_rd, 32'h0000_0041);
    // A genuine overflow sets the flag again right after a clear
    applyStimulus(1'b0, 1'b1, MMIO_BASE, 32'h77, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO_BASE + STATUS_OFFSET, 32'h0, 1'b0);
    checkOutput("overflow_reset", last_rd, 32'h0000_0045);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("last_byte", 32'(last_out), 32'h55);

    // CYCLE increments once per clock and ignores writes
    applyStimulus(1'b1, 1'b0, MMIO_BASE + CYCLE_OFFSET, 32'h0, 1'b0);
    c0 = last_rd;
    applyStimulus(1'b0, 1'b1, MMIO_BASE + CYCLE_OFFSET, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, MMIO_BASE + CYCLE_OFFSET, 32'h0, 1'b0);
    checkOutput("cycle_delta", last_rd - c0, 32'd10);

    // RAM boundaries and an unmapped read
    applyStimulus(1'b0, 1'b1, 32'h1001_00FC, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h1001_00FC, 32'h0, 1'b0);
    checkOutput("ram_last_word", last_rd, 32'hCAFE_F00D);
    checkOutput("no_bus_error", 32'(last_bus), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    checkOutput("unmapped_read", last_rd, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("bus_error_sticky", 32'(last_bus), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h1001_0100, 32'h0, 1'b0);
    checkOutput("past_ram_end", last_rd, 32'h0);

    // Randomized traffic with occasional resets
    doReset();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) doReset();
      pick  = int'($urandom_range(0, 99));
      wdata = $urandom;
      if (pick < 45)
        addr = RAM_BASE + 32'($urandom_range(0, MEMORY_DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      else if (pick < 70) addr = MMIO_BASE + TXDATA_OFFSET;
      else if (pick < 85) addr = MMIO_BASE + STATUS_OFFSET;
      else if (pick < 95) addr = MMIO_BASE + CYCLE_OFFSET + 32'($urandom_range(0, 3));
      else if (pick < 97) addr = 32'h1000_FFFC;
      else if (pick < 98) addr = MMIO_BASE + 32'hC;
      else addr = $urandom;
      if (pick >= 95 && $urandom_range(0, 3) != 0) addr = RAM_BASE;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, wdata,
                    1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
